// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared constants and the sequencer state type for the RV32I control path.
package rv32i_pkg;
  localparam logic [6:0]  OPC_OP_IMM   = 7'b0010011;
  localparam logic [2:0]  F3_SLLI      = 3'b001;
  localparam logic [2:0]  F3_SRLI_SRAI = 3'b101;
  localparam logic [6:0]  F7_ZERO      = 7'b0000000;
  localparam logic [6:0]  F7_SRA       = 7'b0100000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_WAIT, S_DECODE, S_EXECUTE, S_WRITEBACK, S_TRAP
  } seq_state_e;
endpackage

// File: rtl/rv32i_legal_check.sv
// rv32i_legal_check: flags OP-IMM instructions with a valid funct3/funct7 pairing as legal.
module rv32i_legal_check import rv32i_pkg::*; (
  input  logic [31:0] i_ir,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  output logic        o_legal
);
  logic [6:0] w_f7;
  assign w_f7 = i_ir[31:25];
  always_comb
    o_legal = (i_opcode == OPC_OP_IMM) &&
              ((i_funct3 == F3_SLLI)      ? (w_f7 == F7_ZERO) :
               (i_funct3 == F3_SRLI_SRAI) ? (w_f7 == F7_ZERO || w_f7 == F7_SRA) : 1'b1);
endmodule

// File: rtl/rv32i_sequencer.sv
// rv32i_sequencer: multi-cycle fetch/decode/execute/writeback control FSM for OP-IMM-only RV32I.
// Define RV32I_SEQ_PERF_COUNTERS_EN to build the instret/cycle counters; otherwise they read 0.
module rv32i_sequencer import rv32i_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instruction,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  output logic        o_rf_re,
  output logic        o_alu_en,
  output logic        o_rf_we,
  output logic        o_retire,
  output logic        o_illegal,
  output logic [31:0] o_pc,
  output logic [31:0] o_instret,
  output logic [31:0] o_cycle
);
  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};
  seq_state_e  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic        w_legal;
  rv32i_legal_check u_legal (
    .i_ir     (r_ir),
    .i_opcode (i_opcode),
    .i_funct3 (i_funct3),
    .o_legal  (w_legal)
  );
  // TRAP is terminal: only the asynchronous reset leaves it.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= S_BOOT;
      r_pc    <= PC_INIT;
      r_ir    <= NOP_INSTR;
    end else begin
      case (r_state)
        S_BOOT: r_state <= S_FETCH;
        S_FETCH, S_WAIT:
          if (r_state == S_WAIT || !i_stall) begin
            if (i_imem_rvalid) begin
              r_ir    <= i_imem_rdata;
              r_state <= S_DECODE;
            end else r_state <= S_WAIT;
          end
        S_DECODE:    r_state <= w_legal ? S_EXECUTE : S_TRAP;
        S_EXECUTE:   r_state <= S_WRITEBACK;
        S_WRITEBACK: begin
          r_pc    <= r_pc + 32'd4;
          r_state <= S_FETCH;
        end
        default: r_state <= S_TRAP;
      endcase
    end
  assign o_imem_req    = (r_state == S_FETCH && !i_stall) || r_state == S_WAIT;
  assign o_imem_addr   = r_pc;
  assign o_pc          = r_pc;
  assign o_instruction = r_ir;
  assign o_rf_re       = r_state == S_DECODE;
  assign o_alu_en      = r_state == S_EXECUTE;
  assign o_retire      = r_state == S_WRITEBACK;
  assign o_rf_we       = o_retire && (r_ir[11:7] != 5'd0);
  assign o_illegal     = r_state == S_TRAP;
`ifdef RV32I_SEQ_PERF_COUNTERS_EN
  logic [31:0] r_instret;
  logic [31:0] r_cycle;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_instret <= '0;
      r_cycle   <= '0;
    end else begin
      if (r_state != S_BOOT) r_cycle <= r_cycle + 32'd1;
      if (o_retire) r_instret <= r_instret + 32'd1;
    end
  assign o_instret = r_instret;
  assign o_cycle   = r_cycle;
`else
  assign o_instret = '0;
  assign o_cycle   = '0;
`endif
endmodule

// File: tb/tb_rv32i_sequencer.sv
// tb_rv32i_sequencer: directed bench with a retire scoreboard and a wait-state memory responder.
module tb_rv32i_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, rvalid = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic req, rf_re, alu_en, rf_we, retire, illegal;
  logic [31:0] addr, instr, pc, instret, cycle;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic stall_b = 1'b0;
  logic [31:0] rdata_b = 32'h0000_0013;
  logic req_b, rvalid_b, rf_re_b, alu_en_b, rf_we_b, retire_b, illegal_b;
  logic [31:0] addr_b, instr_b, pc_b, instret_b, cycle_b;
  logic [6:0] opcode_b;
  logic [2:0] funct3_b;

  always #5 clk = ~clk;
  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign opcode_b = instr_b[6:0];
  assign funct3_b = instr_b[14:12];
  assign rvalid_b = req_b;

  rv32i_sequencer #(.RESET_PC(32'h0000_0100)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .o_imem_req(req), .o_imem_addr(addr),
    .i_imem_rvalid(rvalid), .i_imem_rdata(rdata), .o_instruction(instr), .i_opcode(opcode),
    .i_funct3(funct3), .o_rf_re(rf_re), .o_alu_en(alu_en), .o_rf_we(rf_we), .o_retire(retire),
    .o_illegal(illegal), .o_pc(pc), .o_instret(instret), .o_cycle(cycle));

  // Unaligned top-of-memory reset PC: exercises bit forcing and the PC wrap.
  rv32i_sequencer #(.RESET_PC(32'hFFFF_FFFF)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall_b), .o_imem_req(req_b), .o_imem_addr(addr_b),
    .i_imem_rvalid(rvalid_b), .i_imem_rdata(rdata_b), .o_instruction(instr_b), .i_opcode(opcode_b),
    .i_funct3(funct3_b), .o_rf_re(rf_re_b), .o_alu_en(alu_en_b), .o_rf_we(rf_we_b),
    .o_retire(retire_b), .o_illegal(illegal_b), .o_pc(pc_b), .o_instret(instret_b),
    .o_cycle(cycle_b));

  typedef struct packed {logic [31:0] pc; logic [31:0] ir; logic we;} ret_t;
  ret_t exp_q[$];
  logic [31:0] mem [logic [31:0]];
  int checks = 0, errors = 0, retired = 0, mem_wait = 0, wcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_ret(input logic [31:0] a, input logic [31:0] ir, input logic we);
    ret_t e;
    e.pc = a; e.ir = ir; e.we = we;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(negedge clk);
    if (req) begin
      if (wcnt >= mem_wait) begin
        rvalid = 1'b1;
        rdata  = mem.exists(addr) ? mem[addr] : 32'h0000_0013;
      end else begin
        rvalid = 1'b0;
        wcnt++;
      end
    end else begin
      rvalid = 1'b0;
      wcnt   = 0;
    end
  end

  initial begin : monitor
    ret_t e;
    forever begin
      @(negedge clk);
      if (retire) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL retire_unexpected: got retire at pc %h expected none", pc);
        end else begin
          e = exp_q.pop_front();
          chk("ret_pc", pc, e.pc);
          chk("ret_ir", instr, e.ir);
          chk("ret_we", {31'd0, rf_we}, {31'd0, e.we});
        end
        retired++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  logic [31:0] prog [10] = '{32'h00108093, 32'h00121213, 32'h4011D193, 32'h00000013, 32'h00500113,
                             32'h00305193, 32'h00108093, 32'h00121213, 32'hFFF00093, 32'h00007013};
  logic [9:0] prog_we = 10'b0111110111;

  initial begin
    int n, r0;
    mem[32'h100] = 32'h00108093; expect_ret(32'h100, 32'h00108093, 1'b1);
    mem[32'h104] = 32'h00000013; expect_ret(32'h104, 32'h00000013, 1'b0);
    mem[32'h108] = 32'h4011D193; expect_ret(32'h108, 32'h4011D193, 1'b1);
    mem[32'h10C] = 32'h00000033;
    #12;
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_pc", pc, 32'h100);
    chk("rst_ir", instr, 32'h13);
    chk("rst_strobes", {27'd0, rf_re, alu_en, rf_we, retire, illegal}, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_cycle", cycle, 32'd0);
    chk("b_rst_pc", pc_b, 32'hFFFF_FFFC);
    @(posedge clk); #1 rst_n = 1'b1;
    chk("boot_req", {31'd0, req}, 32'd0);
    tick();
    chk("fetch_req", {31'd0, req}, 32'd1);
    chk("fetch_addr", addr, 32'h100);
    chk("b_fetch_addr", addr_b, 32'hFFFF_FFFC);
    tick();
    chk("decode_strobes", {28'd0, rf_re, alu_en, rf_we, retire}, 32'b1000);
    chk("decode_ir", instr, 32'h00108093);
    tick();
    chk("exec_strobes", {28'd0, rf_re, alu_en, rf_we, retire}, 32'b0100);
    tick();
    chk("wb_strobes", {28'd0, rf_re, alu_en, rf_we, retire}, 32'b0011);
    chk("wb_pc", pc, 32'h100);
    tick();
    chk("fetch2_req", {31'd0, req}, 32'd1);
    chk("fetch2_addr", addr, 32'h104);
    chk("b_wrap_addr", addr_b, 32'h0);
    tick(); tick(); tick();
    chk("rd0_strobes", {28'd0, rf_re, alu_en, rf_we, retire}, 32'b0001);
    mem_wait = 3;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("wait_req", {31'd0, req}, 32'd1);
      chk("wait_addr", addr, 32'h108);
      chk("wait_ir", instr, 32'h13);
      tick();
    end
    chk("wait_capture", instr, 32'h4011D193);
    chk("wait_decode", {31'd0, rf_re}, 32'd1);
    mem_wait = 0;
    tick(); tick();
    stall = 1'b1;
    chk("srai_wb", {28'd0, rf_re, alu_en, rf_we, retire}, 32'b0011);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_req", {31'd0, req}, 32'd0);
    end
    tick();
    stall = 1'b0;
    #1;
    chk("unstall_req", {31'd0, req}, 32'd1);
    chk("unstall_addr", addr, 32'h10C);
    tick();
    chk("ill1_decode", {31'd0, rf_re}, 32'd1);
    tick();
    chk("ill1_flag", {31'd0, illegal}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("ill1_hold", {29'd0, illegal, req, retire}, 32'b100);
      chk("ill1_pc", pc, 32'h10C);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_trap_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_trap_pc", pc, 32'h100);
    chk("rst_trap_ir", instr, 32'h13);
    mem[32'h100] = 32'h40001013;
    @(posedge clk); #1 rst_n = 1'b1;
    tick(); tick(); tick();
    chk("ill2_flag", {31'd0, illegal}, 32'd1);
    chk("ill2_pc", pc, 32'h100);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ill2_hold", {29'd0, illegal, req, retire}, 32'b100);
    end
    #2 rst_n = 1'b0;
    mem[32'h100] = 32'h00108093;
    @(posedge clk); #1 rst_n = 1'b1;
    tick(); tick(); tick();
    chk("pre_rst_alu", {31'd0, alu_en}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outs", {26'd0, req, rf_re, alu_en, rf_we, retire, illegal}, 32'd0);
    chk("midrst_pc", pc, 32'h100);
    chk("midrst_ir", instr, 32'h13);
    chk("midrst_instret", instret, 32'd0);
    chk("midrst_cycle", cycle, 32'd0);
    for (int k = 0; k < 10; k++) begin
      mem[32'h100 + 32'(4 * k)] = prog[k];
      expect_ret(32'h100 + 32'(4 * k), prog[k], prog_we[k]);
    end
    r0 = retired;
    @(posedge clk); #1 rst_n = 1'b1;
    n = 0;
    while (retired < r0 + 10 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL retire_timeout: got %0d retires expected 10", retired - r0);
    end
`ifdef RV32I_SEQ_PERF_COUNTERS_EN
    chk("perf_instret", instret, 32'd10);
    chk("perf_cycle", cycle, 32'd40);
`else
    chk("noperf_instret", instret, 32'd0);
    chk("noperf_cycle", cycle, 32'd0);
`endif
    chk("post_pc", pc, 32'h128);
    rst_n = 1'b0;
    #1;
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
